encode83_capture: RTL and testbench
===================================

ENCODE83_CAPTURE -- requirements
Module: encode83_capture

Interface
REQ-001 The block SHALL have one parameter: SYNC_STAGES, default 2, number of synchronizer flops per input line (legal 2..4).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 y_in  input  8  asynchronous event request lines; line i encodes to code i.
REQ-005 code_out  output  3  binary index of the delivered event.
REQ-006 code_valid  output  1  code_out holds an undelivered event.
REQ-007 code_ready  input  1  consumer accepts code_out; transfer on any edge with code_valid=1 and code_ready=1.
REQ-008 pend_out  output  8  registered pending-event bitmap.
REQ-009 lost_cnt  output  4  saturating count of dropped events.
REQ-010 idle  output  1  high when pend_out=0 and code_valid=0.

Function
REQ-011 Each y_in bit SHALL pass through a SYNC_STAGES-deep flop chain (y_s) before any use.
REQ-012 A registered copy y_prev SHALL hold the previous y_s; rise[i] = y_s[i] & ~y_prev[i].
REQ-013 pend[i] SHALL set at the edge where rise[i]=1, and clear at the edge where line i is loaded into the output register.
REQ-014 Set and clear of the same pend bit on one edge: set SHALL win (bit stays 1, event emitted again later).
REQ-015 Rise on a line whose pend bit is 1 and not being cleared that edge: event SHALL be dropped and lost_cnt incremented, saturating at 15; multiple such drops on one edge SHALL add their count, still saturating.
REQ-016 Output register SHALL load when pend/=0 and (code_valid=0 or code_ready=1): code_out = highest set index of pend, code_valid=1, that pend bit cleared.
REQ-017 Transfer with pend=0 SHALL drop code_valid to 0 on that edge.
REQ-018 While code_valid=1 and code_ready=0, code_out SHALL hold stable.
REQ-019 Back-to-back: with code_ready=1 held, one code SHALL be delivered per cycle, highest index first.
REQ-020 Latency (SYNC_STAGES=2, consumer ready): y_in high before edge 0 -> pend bit set at edge 2, code_valid=1 after edge 3.
REQ-021 Selection uses registered pend only; rises arriving on the load edge are not eligible until the next edge.
REQ-022 idle, pend_out, lost_cnt SHALL be direct register outputs or decoded only from registers.
REQ-023 A y_in level held high SHALL produce exactly one event; falling edges produce none.

Reset
REQ-024 On rst=1: sync chains=0, y_prev=8'hFF, pend=0, code_out=0, code_valid=0, lost_cnt=0; idle=1 the cycle after.
REQ-025 Reset SHALL override all concurrent events, including mid-handshake; undelivered codes and pending events are discarded.
REQ-026 A line high through reset release SHALL NOT generate an event; it generates one only after going low then high.

Verification
REQ-027 After reset, y_in=8'h20 for 3 cycles, code_ready=1 -> code_valid=1 with code_out=5 after edge 3, low one cycle later, idle=1.
REQ-028 y_in 8'h00->8'h85 in one cycle, code_ready=0 for 10 cycles -> code_out=7 stable, pend_out=8'h05; then code_ready=1 -> codes 7,2,0 on consecutive transfers, then idle=1.
REQ-029 code_ready=0, line 3 pulsed (2 high / 2 low) 22 times -> one pending event, lost_cnt increments to 15 and stays 15.
REQ-030 y_in=8'hFF held through reset release for 20 cycles -> code_valid=0, pend_out=0, idle=1 throughout.
REQ-031 rst asserted with code_valid=1, pend_out=8'h0C, lost_cnt=4 -> next edge all zero, idle=1; no code delivered after release.
REQ-032 Line 4 rise timed to the edge pend[4] is loaded -> code 4 delivered twice, lost_cnt unchanged.

Source files
------------

// File: rtl/encode83_capture.sv
// Captures rising edges on eight asynchronous request lines into a pending bitmap
// and delivers them as 3-bit codes through a valid/ready output register, highest index first.
module encode83_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] y_in,
  output logic [2:0] code_out,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [7:0] pend_out,
  output logic [3:0] lost_cnt,
  output logic       idle
);

  logic [7:0]             r_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_vld;
  logic [7:0]             r_prev;
  logic [7:0]             r_pend;
  logic [2:0]             r_code;
  logic                   r_valid;
  logic [3:0]             r_lost;

  logic [7:0] w_ys;
  logic [7:0] w_rise;
  logic [7:0] w_clr;
  logic [7:0] w_drop;
  logic [2:0] w_sel;
  logic [3:0] w_drop_cnt;
  logic [4:0] w_lost_sum;
  logic       w_load;

  assign w_ys = r_sync[SYNC_STAGES-1];

  // Edge detection stays disarmed until the chain holds post-reset samples, so a line
  // high through reset release is taken as already high and never produces an event.
  assign w_rise = r_vld[SYNC_STAGES-1] ? (w_ys & ~r_prev) : '0;

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r_pend[i]) w_sel = i[2:0];
    end
  end

  assign w_load = (r_pend != '0) && (!r_valid || code_ready);
  assign w_clr  = w_load ? (8'd1 << w_sel) : '0;
  assign w_drop = w_rise & r_pend & ~w_clr;

  always_comb begin
    w_drop_cnt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_drop_cnt = w_drop_cnt + {3'b000, w_drop[i]};
    end
  end

  assign w_lost_sum = {1'b0, r_lost} + {1'b0, w_drop_cnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_vld   <= '0;
      r_prev  <= '1;
      r_pend  <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_lost  <= '0;
    end else begin
      r_sync[0] <= y_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_vld <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      if (r_vld[SYNC_STAGES-1]) r_prev <= w_ys;
      // Set is applied after clear so a rise on the loading edge re-arms the line.
      r_pend <= (r_pend & ~w_clr) | w_rise;
      if (w_load) begin
        r_code  <= w_sel;
        r_valid <= 1'b1;
      end else if (code_ready) begin
        r_valid <= 1'b0;
      end
      r_lost <= (w_lost_sum > 5'd15) ? 4'hF : w_lost_sum[3:0];
    end
  end

  assign code_out   = r_code;
  assign code_valid = r_valid;
  assign pend_out   = r_pend;
  assign lost_cnt   = r_lost;
  assign idle       = (r_pend == '0) && !r_valid;

endmodule

// File: tb/tb_encode83_capture.sv
// Bench for encode83_capture: directed scenarios plus random traffic, every cycle
// compared against an event-level reference model.
module tb_encode83_capture;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] y_in = '0;
  logic       code_ready = 1'b0;
  logic [2:0] code_out;
  logic       code_valid;
  logic [7:0] pend_out;
  logic [3:0] lost_cnt;
  logic       idle;

  int total = 0;
  int bad   = 0;

  encode83_capture #(.SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .y_in       (y_in),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pend_out   (pend_out),
    .lost_cnt   (lost_cnt),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  // Reference model: history of samples seen by the chain, last accepted line level,
  // pending set, output slot and lost counter.
  logic [7:0] m_hist [S];
  int         m_since;
  logic [7:0] m_prev;
  logic [7:0] m_pend;
  int         m_code;
  logic       m_valid;
  int         m_lost;

  task automatic model_edge();
    logic [7:0] ys;
    logic [7:0] newpend;
    bit         armed;
    bit         load;
    int         hi;
    int         drops;
    if (rst) begin
      for (int k = 0; k < S; k++) m_hist[k] = '0;
      m_since = 0;
      m_prev  = 8'hFF;
      m_pend  = '0;
      m_code  = 0;
      m_valid = 1'b0;
      m_lost  = 0;
    end else begin
      ys    = m_hist[S-1];
      armed = (m_since >= S);
      hi    = -1;
      for (int k = 7; k >= 0; k--) if (m_pend[k] && hi < 0) hi = k;
      load    = (hi >= 0) && (!m_valid || code_ready);
      newpend = m_pend;
      if (load) newpend[hi] = 1'b0;
      drops = 0;
      for (int k = 0; k < 8; k++) begin
        if (armed && ys[k] && !m_prev[k]) begin
          if (m_pend[k] && !(load && hi == k)) drops++;
          newpend[k] = 1'b1;
        end
      end
      m_pend = newpend;
      m_lost = (m_lost + drops > 15) ? 15 : m_lost + drops;
      if (load) begin
        m_code  = hi;
        m_valid = 1'b1;
      end else if (code_ready) begin
        m_valid = 1'b0;
      end
      if (armed) m_prev = ys;
      for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = y_in;
      if (m_since < 1000) m_since++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", {7'd0, code_valid}, {7'd0, m_valid});
    chk("code",  {5'd0, code_out},   8'(m_code));
    chk("pend",  pend_out,           m_pend);
    chk("lost",  {4'd0, lost_cnt},   8'(m_lost));
    chk("idle",  {7'd0, idle},       {7'd0, (m_pend == 8'h00) && !m_valid});
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  int saved_lost;
  logic [7:0] cur;

  initial begin
    // Reset state and quiet settle
    y_in = '0;
    code_ready = 1'b1;
    do_reset();
    chk("rst_idle", {7'd0, idle}, 8'd1);
    chk("rst_valid", {7'd0, code_valid}, 8'd0);
    steps(4);

    // Single event on line 5 with consumer ready
    y_in = 8'h20;
    steps(3);
    y_in = 8'h00;
    step();
    chk("l5_valid", {7'd0, code_valid}, 8'd1);
    chk("l5_code", {5'd0, code_out}, 8'd5);
    step();
    chk("l5_drop", {7'd0, code_valid}, 8'd0);
    chk("l5_idle", {7'd0, idle}, 8'd1);
    steps(3);

    // Three simultaneous events, consumer stalled, then drained in priority order
    code_ready = 1'b0;
    y_in = 8'h85;
    steps(12);
    chk("stall_code", {5'd0, code_out}, 8'd7);
    chk("stall_pend", pend_out, 8'h05);
    code_ready = 1'b1;
    step();
    chk("drain_c2", {5'd0, code_out}, 8'd2);
    step();
    chk("drain_c0", {5'd0, code_out}, 8'd0);
    step();
    chk("drain_end", {7'd0, code_valid}, 8'd0);
    chk("drain_idle", {7'd0, idle}, 8'd1);
    y_in = 8'h00;
    steps(4);

    // Repeated pulses on line 3 while stalled saturate the lost counter
    code_ready = 1'b0;
    for (int p = 0; p < 22; p++) begin
      y_in = 8'h08;
      steps(2);
      y_in = 8'h00;
      steps(2);
    end
    steps(2);
    chk("sat_lost", {4'd0, lost_cnt}, 8'd15);
    chk("sat_pend", pend_out, 8'h08);
    code_ready = 1'b1;
    steps(4);
    chk("sat_hold", {4'd0, lost_cnt}, 8'd15);

    // All lines high through reset release
    y_in = 8'hFF;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step();
      chk("hi_valid", {7'd0, code_valid}, 8'd0);
      chk("hi_pend", pend_out, 8'h00);
    end
    y_in = 8'h00;
    steps(4);

    // Reset in the middle of a stalled handshake with pending and lost events
    do_reset();
    steps(3);
    code_ready = 1'b0;
    y_in = 8'h80; steps(2); y_in = 8'h00; steps(2);
    for (int p = 0; p < 3; p++) begin
      y_in = 8'h0C; steps(2); y_in = 8'h00; steps(2);
    end
    steps(2);
    chk("pre_valid", {7'd0, code_valid}, 8'd1);
    chk("pre_pend", pend_out, 8'h0C);
    chk("pre_lost", {4'd0, lost_cnt}, 8'd4);
    code_ready = 1'b1;
    rst = 1'b1;
    step();
    chk("mid_valid", {7'd0, code_valid}, 8'd0);
    chk("mid_pend", pend_out, 8'h00);
    chk("mid_lost", {4'd0, lost_cnt}, 8'd0);
    chk("mid_idle", {7'd0, idle}, 8'd1);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_valid", {7'd0, code_valid}, 8'd0);
    end

    // Line 4 rising on the very edge its pending bit is loaded
    code_ready = 1'b0;
    y_in = 8'h80; steps(2); y_in = 8'h00; steps(2);
    y_in = 8'h10; steps(2); y_in = 8'h00; steps(2);
    saved_lost = int'(lost_cnt);
    y_in = 8'h10;
    steps(2);
    code_ready = 1'b1;
    step();
    chk("race_code", {5'd0, code_out}, 8'd4);
    chk("race_pend", pend_out, 8'h10);
    y_in = 8'h00;
    step();
    chk("race_again", {5'd0, code_out}, 8'd4);
    chk("race_valid", {7'd0, code_valid}, 8'd1);
    chk("race_lost", {4'd0, lost_cnt}, 8'(saved_lost));
    steps(3);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      cur = y_in;
      for (int k = 0; k < 8; k++) if ($urandom_range(0, 7) == 0) cur[k] = ~cur[k];
      y_in = cur;
      code_ready = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
